// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: PC holder issuing single outstanding word fetches and handing
// instructions to decode over valid/ready, with redirect and stale-fetch drop. Rev 1.0
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            r_clk,
   input  logic            r_rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            err_spurious
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic            err_q, err_d;

   logic [XLEN-1:0] redir_pc;
   logic            req_hs;

   assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
   // Gated by reset so no request leaks out while the core is held in reset.
   assign imem_req_valid = r_rst_n && (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign if_valid     = if_valid_q;
   assign if_pc        = if_pc_q;
   assign if_instr     = if_instr_q;
   assign err_spurious = err_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      err_d      = err_q;
      case (state_q)
         S_REQ: begin
            if (imem_rsp_valid) err_d = 1'b1;
            if (req_hs && redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_DROP;
            end else if (req_hs) begin
               state_d = S_WAIT;
            end else if (redirect_valid) begin
               pc_d = redir_pc;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid && redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (imem_rsp_valid) begin
               if_instr_d = imem_rsp_data;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_q + XLEN'(4);
               state_d    = S_HOLD;
            end else if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            if (imem_rsp_valid) err_d = 1'b1;
            if (redirect_valid) begin
               if_valid_d = 1'b0;
               pc_d       = redir_pc;
               state_d    = S_REQ;
            end else if (if_ready) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) pc_d = redir_pc;
            if (imem_rsp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         err_q      <= err_d;
      end
   end

endmodule
`default_nettype wire
